// File: rtl/median_frame_ctrl.sv
// Frame sequencer for the 3x3 binary median window scanner: hands a buffered frame to the
// scanner, waits for completion, thresholds the active-window count and releases the buffer.
module median_frame_ctrl #(
    parameter int unsigned COUNT_WIDTH    = 13,
    parameter int unsigned ACTIVE_THRESH  = 100,
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned TIMER_WIDTH    = 21
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   frame_valid,
    output logic                   frame_release,
    output logic                   filter_init,
    output logic                   filter_start,
    input  logic                   filter_done,
    input  logic [COUNT_WIDTH-1:0] filter_count,
    output logic [COUNT_WIDTH-1:0] result_count,
    output logic                   result_detect,
    output logic                   result_valid,
    output logic                   timeout_err,
    output logic [15:0]            frames_done,
    output logic                   busy
);

    localparam int unsigned SETTLE_WIDTH = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, REPORT} stateT;

    stateT                   state;
    stateT                   nextState;
    logic [TIMER_WIDTH-1:0]  watchdog;
    logic [SETTLE_WIDTH-1:0] settleCnt;
    logic [COUNT_WIDTH-1:0]  resultCount;
    logic                    resultDetect;
    logic [15:0]             framesCnt;
    logic                    timeoutErr;
    logic                    timeoutPulse;
    logic                    timeoutHit;
    logic                    settleDone;
    logic                    countActive;

    // Comparisons done at 32 bits so no parameter value gets truncated.
    assign timeoutHit  = (32'(watchdog) == TIMEOUT_CYCLES - 1);
    assign settleDone  = (32'(settleCnt) == SETTLE_CYCLES - 1);
    assign countActive = (32'(filter_count) >= ACTIVE_THRESH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (enable && frame_valid) nextState = INIT;
            INIT:    nextState = RUN;
            RUN: begin
                if (filter_done)     nextState = DRAIN;
                else if (timeoutHit) nextState = IDLE;
            end
            DRAIN:   if (settleDone) nextState = REPORT;
            REPORT:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            watchdog     <= '0;
            settleCnt    <= '0;
            resultCount  <= '0;
            resultDetect <= 1'b0;
            framesCnt    <= '0;
            timeoutErr   <= 1'b0;
            timeoutPulse <= 1'b0;
        end else begin
            timeoutPulse <= 1'b0;
            case (state)
                INIT: watchdog <= '0;
                RUN: begin
                    watchdog <= watchdog + TIMER_WIDTH'(1);
                    if (filter_done) begin
                        settleCnt <= '0;
                    end else if (timeoutHit) begin
                        timeoutErr   <= 1'b1;
                        timeoutPulse <= 1'b1;
                    end
                end
                DRAIN: begin
                    settleCnt <= settleCnt + SETTLE_WIDTH'(1);
                    if (settleDone) begin
                        resultCount  <= filter_count;
                        resultDetect <= countActive;
                    end
                end
                REPORT: if (framesCnt != '1) framesCnt <= framesCnt + 16'd1;
                default: ;
            endcase
        end
    end

    // Timeout release is registered, so it appears in the first IDLE cycle after RUN.
    always_comb begin
        filter_init   = (state == INIT);
        filter_start  = (state == RUN) || (state == DRAIN);
        result_valid  = (state == REPORT);
        frame_release = (state == REPORT) || timeoutPulse;
        busy          = (state != IDLE);
        result_count  = resultCount;
        result_detect = resultDetect;
        timeout_err   = timeoutErr;
        frames_done   = framesCnt;
    end

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Directed and randomized frames against a cycle-level behavioural model of the sequencer.
module tb_median_frame_ctrl;

    localparam int unsigned CW     = 13;
    localparam int unsigned THRESH = 100;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned TMO    = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          frame_valid;
    logic          frame_release;
    logic          filter_init;
    logic          filter_start;
    logic          filter_done;
    logic [CW-1:0] filter_count;
    logic [CW-1:0] result_count;
    logic          result_detect;
    logic          result_valid;
    logic          timeout_err;
    logic [15:0]   frames_done;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [CW-1:0] mCount;
    logic          mDetect;
    logic [15:0]   mFrames;
    logic          mTimeout;

    int            rndDelay;
    logic [CW-1:0] rndCount;

    median_frame_ctrl #(
        .COUNT_WIDTH   (CW),
        .ACTIVE_THRESH (THRESH),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO),
        .TIMER_WIDTH   (7)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .frame_valid  (frame_valid),
        .frame_release(frame_release),
        .filter_init  (filter_init),
        .filter_start (filter_start),
        .filter_done  (filter_done),
        .filter_count (filter_count),
        .result_count (result_count),
        .result_detect(result_detect),
        .result_valid (result_valid),
        .timeout_err  (timeout_err),
        .frames_done  (frames_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        mCount   = '0;
        mDetect  = 1'b0;
        mFrames  = '0;
        mTimeout = 1'b0;
    endtask

    task automatic chkQuiet(input string tag);
        chk({tag, "_ctl"}, {busy, filter_init, filter_start, frame_release, result_valid}, 0);
        chk({tag, "_count"}, result_count, mCount);
        chk({tag, "_detect"}, result_detect, mDetect);
        chk({tag, "_frames"}, frames_done, mFrames);
        chk({tag, "_timeout"}, timeout_err, mTimeout);
    endtask

    // One complete frame, entered from IDLE; scanner raises done on RUN cycle 'delay'.
    task automatic runFrame(input int delay, input logic [CW-1:0] cnt, input bit keepValid,
                            input int dropAt);
        frame_valid = 1'b1;
        chk("idle_before_frame", busy, 0);
        tick();
        chk("init_pulse", {filter_init, filter_start, busy}, 3'b101);
        tick();
        for (int k = 0; k <= delay; k++) begin
            chk("run_outputs", {filter_init, filter_start, frame_release, result_valid}, 4'b0100);
            if (k == dropAt) enable = 1'b0;
            filter_done  = (k == delay);
            filter_count = (k == delay) ? cnt : CW'($urandom);
            tick();
        end
        filter_done = 1'b0;
        for (int c = 1; c <= int'(SETTLE); c++) begin
            chk("drain_outputs", {filter_start, result_valid, frame_release}, 3'b100);
            tick();
        end
        mCount  = cnt;
        mDetect = (int'(cnt) >= int'(THRESH));
        if (mFrames != 16'hFFFF) mFrames = mFrames + 16'd1;
        chk("report_pulses", {result_valid, frame_release, filter_start, busy}, 4'b1101);
        chk("report_count", result_count, mCount);
        chk("report_detect", result_detect, mDetect);
        filter_count = CW'($urandom);
        frame_valid  = keepValid;
        tick();
        chk("after_report", {busy, result_valid, frame_release}, 3'b000);
        chk("frames_done", frames_done, mFrames);
        chk("result_hold", result_count, mCount);
    endtask

    task automatic runTimeout();
        frame_valid = 1'b1;
        tick();
        chk("to_init", filter_init, 1);
        tick();
        for (int k = 0; k < int'(TMO); k++) begin
            chk("to_run", {filter_start, frame_release, result_valid, timeout_err},
                {1'b1, 1'b0, 1'b0, mTimeout});
            filter_count = CW'($urandom);
            tick();
        end
        frame_valid = 1'b0;
        mTimeout    = 1'b1;
        chk("to_release", {frame_release, timeout_err, busy, filter_start, result_valid}, 5'b11000);
        chk("to_count_kept", result_count, mCount);
        chk("to_frames_kept", frames_done, mFrames);
        tick();
        chk("to_release_once", {frame_release, timeout_err, busy}, 3'b010);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        frame_valid  = 1'b0;
        filter_done  = 1'b0;
        filter_count = '0;
        clearModel();
        tick();
        tick();
        chkQuiet("reset_state");
        reset = 1'b0;
        tick();
        chkQuiet("post_reset");

        enable = 1'b1;
        runFrame(50, 13'd120, 1'b0, -1);
        runFrame(10, 13'd99, 1'b0, -1);
        runFrame(5, 13'd100, 1'b0, -1);
        runFrame(int'(TMO) - 1, 13'd0, 1'b0, -1);
        runFrame(0, 13'h1FFF, 1'b0, -1);

        runTimeout();

        runFrame(7, 13'd300, 1'b1, -1);
        runFrame(3, 13'd42, 1'b1, -1);
        runFrame(12, 13'd101, 1'b0, -1);

        for (int i = 0; i < 8; i++) begin
            rndDelay = int'($urandom_range(0, TMO - 1));
            rndCount = (i % 2 == 1) ? CW'($urandom_range(THRESH - 3, THRESH + 3)) : CW'($urandom);
            runFrame(rndDelay, rndCount, (i % 3 == 0), -1);
        end

        // enable dropped mid-frame: frame completes, then no restart; done is ignored in IDLE
        runFrame(20, 13'd150, 1'b1, 5);
        filter_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("enable_off_idle", {busy, filter_init, filter_start, result_valid}, 4'b0000);
        end
        filter_done = 1'b0;
        chk("enable_off_frames", frames_done, mFrames);

        // reset during RUN
        enable      = 1'b1;
        frame_valid = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("pre_reset_run", filter_start, 1);
        reset       = 1'b1;
        frame_valid = 1'b0;
        tick();
        clearModel();
        chkQuiet("reset_in_run");
        reset = 1'b0;
        tick();
        chkQuiet("after_reset_run");

        // reset during DRAIN
        frame_valid = 1'b1;
        tick();
        tick();
        filter_done  = 1'b1;
        filter_count = 13'd500;
        tick();
        filter_done = 1'b0;
        chk("pre_reset_drain", {filter_start, result_valid}, 2'b10);
        frame_valid = 1'b0;
        reset       = 1'b1;
        tick();
        chkQuiet("reset_in_drain");
        reset = 1'b0;
        tick();
        tick();
        chkQuiet("after_reset_drain");

        // frame counter saturation
        force dut.framesCnt = 16'hFFFE;
        tick();
        release dut.framesCnt;
        mFrames = 16'hFFFE;
        tick();
        chk("preload_frames", frames_done, mFrames);
        runFrame(4, 13'd77, 1'b0, -1);
        chk("frames_at_max", frames_done, 16'hFFFF);
        runFrame(9, 13'd2000, 1'b0, -1);
        chk("frames_saturated", frames_done, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
